// File: rtl/imm_extend_stage.sv
// imm_extend_stage: immediate extension for the multi-cycle CPU datapath.
// The raw immediate is extended when it is pushed. The result then sits in a
// 2-entry FIFO, so decode and execute can stall independently.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. A producer holding valid keeps its data stable
// until that edge. in_ready is taken from registered occupancy only. It never
// looks at out_ready, so no combinational path runs from in_* to out_*.
module imm_extend_stage #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int ZX_W  = 3,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_ext,
  input  logic [1:0]       imm_source,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [1:0]       out_mode
);

  localparam int EXT_W = IN_W + SHIFT;

  // Reject parameter sets that would truncate the branch immediate or read
  // bits the raw field does not have.
  generate
    if (OUT_W < EXT_W) begin : g_bad_out_w
      $error("imm_extend_stage: OUT_W must be >= IN_W+SHIFT");
    end
    if (ZX_W > IN_W) begin : g_bad_zx_w
      $error("imm_extend_stage: ZX_W must be <= IN_W");
    end
  endgenerate

  // Extension modes.
  localparam logic [1:0] MODE_DP     = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_RAW    = 2'b11;

  // FIFO state.
  logic [OUT_W-1:0] ext_mem_q  [2];
  logic [OUT_W-1:0] ext_mem_d  [2];
  logic [1:0]       mode_mem_q [2];
  logic [1:0]       mode_mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;
  logic [EXT_W-1:0] shifted;
  logic [OUT_W-1:0] ext_val;

  // Extend the incoming immediate according to the selected mode.
  always_comb begin
    shifted = EXT_W'(in_ext) << SHIFT;
    ext_val = '0;
    case (imm_source)
      MODE_DP:     ext_val = OUT_W'(in_ext[ZX_W-1:0]);
      MODE_MEM:    ext_val = OUT_W'(in_ext[ZX_W-1:0]);
      MODE_BRANCH: ext_val = OUT_W'($signed(shifted));
      MODE_RAW:    ext_val = OUT_W'(in_ext);
      default:     ext_val = '0;
    endcase
  end

  // Handshake outputs and head-of-FIFO data, all from registered state.
  // When the FIFO is empty the outputs read as zero.
  always_comb begin
    in_ready  = reset_n && (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_ext   = out_valid ? ext_mem_q[rd_ptr_q]  : '0;
    out_mode  = out_valid ? mode_mem_q[rd_ptr_q] : 2'b00;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers, occupancy and storage.
  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    ext_mem_d  = ext_mem_q;
    mode_mem_d = mode_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        ext_mem_d[wr_ptr_q]  = ext_val;
        mode_mem_d[wr_ptr_q] = imm_source;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. Asynchronous reset clears everything, including storage,
  // so no partial entry survives a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_mem_q[0]  <= '0;
      ext_mem_q[1]  <= '0;
      mode_mem_q[0] <= 2'b00;
      mode_mem_q[1] <= 2'b00;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      ext_mem_q  <= ext_mem_d;
      mode_mem_q <= mode_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage with default parameters
// (IN_W=4, OUT_W=8, ZX_W=3, SHIFT=2).
module tb_imm_extend_stage;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ext;
  logic [1:0] imm_source;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ext;
  logic [1:0] out_mode;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [1:0] exp_mode_q[$];

  imm_extend_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ext     (in_ext),
    .imm_source (imm_source),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ext    (out_ext),
    .out_mode   (out_mode)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference extension with the default parameters written out by hand.
  function automatic logic [7:0] ref_ext(input logic [3:0] x, input logic [1:0] m);
    case (m)
      2'b00, 2'b01: ref_ext = {5'b00000, x[2:0]};
      2'b10:        ref_ext = {{2{x[3]}}, x, 2'b00};
      default:      ref_ext = {4'b0000, x};
    endcase
  endfunction

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [1:0] m);
    in_valid   = v;
    in_ext     = x;
    imm_source = m;
  endtask

  // Stimulus tables for the mode test.
  logic [3:0] mode_x   [5] = '{4'hF, 4'hA, 4'hA, 4'h5, 4'hF};
  logic [1:0] mode_m   [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [7:0] mode_exp [5] = '{8'h07, 8'h02, 8'hE8, 8'h14, 8'h0F};

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 2'b00);

    // 1 reset
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_ext", out_ext, 8'h00);
    check_eq("rst_out_mode", out_mode, 0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);
    tick();
    check_eq("rel_in_ready_edge", in_ready, 1);

    // 2 modes, one per cycle, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mode_x[i], mode_m[i]);
      tick();
      check_eq($sformatf("mode%0d_valid", i), out_valid, 1);
      check_eq($sformatf("mode%0d_ext", i), out_ext, mode_exp[i]);
      check_eq($sformatf("mode%0d_mode", i), out_mode, mode_m[i]);
      check_eq($sformatf("mode%0d_ref", i), out_ext, ref_ext(mode_x[i], mode_m[i]));
    end
    drive(1'b0, 4'h0, 2'b00);
    tick();
    check_eq("mode_drain_valid", out_valid, 0);
    check_eq("mode_drain_ext", out_ext, 8'h00);

    // 3 backpressure
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 2'b00);
    tick();
    check_eq("bp_first_ready", in_ready, 1);
    check_eq("bp_first_ext", out_ext, 8'h03);
    drive(1'b1, 4'hC, 2'b10);
    tick();
    check_eq("bp_full_ready", in_ready, 0);
    check_eq("bp_full_ext", out_ext, 8'h03);
    drive(1'b0, 4'h0, 2'b00);
    tick();
    check_eq("bp_hold_ext", out_ext, 8'h03);
    check_eq("bp_hold_mode", out_mode, 2'b00);
    check_eq("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_head_ext", out_ext, 8'h03);
    tick();
    check_eq("bp_second_ext", out_ext, 8'hF0);
    check_eq("bp_second_mode", out_mode, 2'b10);
    check_eq("bp_second_ready", in_ready, 1);
    tick();
    check_eq("bp_empty_valid", out_valid, 0);

    // 4 simultaneous push/pop at count 1
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 2'b11);
    exp_q.push_back(ref_ext(4'h1, 2'b11));
    exp_mode_q.push_back(2'b11);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] x;
      logic [1:0] m;
      x = 4'($urandom_range(0, 15));
      m = 2'(i % 4);
      drive(1'b1, x, m);
      #1;
      check_eq($sformatf("pp%0d_in_ready", i), in_ready, 1);
      check_eq($sformatf("pp%0d_valid", i), out_valid, 1);
      check_eq($sformatf("pp%0d_ext", i), out_ext, exp_q[0]);
      check_eq($sformatf("pp%0d_mode", i), out_mode, exp_mode_q[0]);
      exp_q.push_back(ref_ext(x, m));
      exp_mode_q.push_back(m);
      tick();
      void'(exp_q.pop_front());
      void'(exp_mode_q.pop_front());
    end
    drive(1'b0, 4'h0, 2'b00);
    check_eq("pp_last_ext", out_ext, exp_q[0]);
    check_eq("pp_last_mode", out_mode, exp_mode_q[0]);
    tick();
    void'(exp_q.pop_front());
    void'(exp_mode_q.pop_front());
    check_eq("pp_drain_valid", out_valid, 0);

    // 5 flush at count 2 with a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 4'h2, 2'b11);
    tick();
    drive(1'b1, 4'h4, 2'b11);
    tick();
    check_eq("fl_full_ready", in_ready, 0);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'h9, 2'b11);
    #1;
    check_eq("fl_cycle_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 2'b00);
    check_eq("fl_after_valid", out_valid, 0);
    check_eq("fl_after_ready", in_ready, 1);
    check_eq("fl_after_ext", out_ext, 8'h00);
    tick();
    check_eq("fl_absent_valid", out_valid, 0);
    drive(1'b1, 4'h6, 2'b11);
    tick();
    drive(1'b0, 4'h0, 2'b00);
    check_eq("fl_next_ext", out_ext, 8'h06);
    tick();
    check_eq("fl_next_drain", out_valid, 0);

    // 6 async reset between edges, mid-stream
    out_ready = 1'b0;
    drive(1'b1, 4'hA, 2'b11);
    tick();
    drive(1'b1, 4'hB, 2'b11);
    tick();
    check_eq("ar_pre_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_valid", out_valid, 0);
    check_eq("ar_in_ready", in_ready, 0);
    check_eq("ar_ext", out_ext, 8'h00);
    check_eq("ar_mode", out_mode, 0);
    drive(1'b0, 4'h0, 2'b00);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("ar_rel_ready", in_ready, 1);
    check_eq("ar_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 4'h7, 2'b00);
    tick();
    drive(1'b0, 4'h0, 2'b00);
    check_eq("ar_first_ext", out_ext, 8'h07);
    check_eq("ar_first_mode", out_mode, 2'b00);
    tick();
    check_eq("ar_drain_valid", out_valid, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
